stopwatch_display_mux: RTL
==========================

// Module: stopwatch_display_mux
// PURPOSE
//  Consumes the 4-digit BCD count produced by the stopwatch counter. Drives a
//  time-multiplexed common-anode 7-segment display: snapshot latch, digit scan
//  with anti-ghost blanking, BCD->segment decode, decimal point, overflow dashes.
//  Sits between the stopwatch counter and the board display pins.
// PARAMETERS
//  DIGITS        4      number of multiplexed digits (digit 0 = least significant)
//  SCAN_DIV      50000  clk cycles per digit slot (>= BLANK_CYCLES+2)
//  BLANK_CYCLES  16     cycles at slot start with all anodes off (anti-ghosting)
//  DP_POS        2      digit index whose decimal point is lit
// PORTS
//  clk        in   1          system clock, rising edge
//  masterreset in  1          asynchronous reset, active-high
//  bcd        in   4*DIGITS   packed BCD digits; bcd[3:0] = digit 0
//  load       in   1          1-cycle strobe: capture bcd/overflow into shadow reg
//  overflow   in   1          counter overflow; captured with load
//  anode      out  DIGITS     digit enables, active-low
//  seg        out  7          {g,f,e,d,c,b,a}, active-low
//  dp         out  1          decimal point, active-low
// BEHAVIOUR
//  - Reset (async, immediate, mid-slot too): anode=all 1, seg=7'h7F, dp=1,
//    slot counter=0, digit index=0, shadow and active regs=0 incl. overflow.
//  - load=1 at posedge: shadow <= {overflow,bcd}. Shadow copied to active reg
//    only at slot boundary (counter==SCAN_DIV-1) -> no mid-digit tearing.
//    load on boundary cycle: new value is in shadow that edge, reaches active
//    at the next boundary.
//  - Slot FSM, 2 states: BLANK (counter<BLANK_CYCLES): anode all 1, seg=7'h7F,
//    dp=1. DRIVE (BLANK_CYCLES..SCAN_DIV-1): anode[idx]=0, others 1.
//    Counter wraps SCAN_DIV-1 -> 0; same edge idx <= (idx==DIGITS-1)?0:idx+1.
//  - Outputs registered: change one cycle after counter/idx state is reached.
//  - Decode: 0..9 -> 40,79,24,30,19,12,02,78,00,10 (hex); nibble A..F -> dash 3F.
//  - Active overflow=1: every digit shows dash 3F, dp=1.
//  - dp=0 only in DRIVE, idx==DP_POS, overflow=0.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined: digit i with i>DP_POS whose nibble and all
//   higher nibbles are 0 shows seg=7'h7F (anode still driven). Overflow wins.
//  Not defined: every digit decoded as above, leading zeros shown.
// STRUCTURE
//  stopwatch_pkg: SEG_0..SEG_9, SEG_DASH, SEG_BLANK constants; slot state typedef.
//  Sub-module bcd_to_seg7 (combinational nibble -> seg, dash for >9);
//  instantiated once on the muxed active nibble.
// TESTING (SCAN_DIV=8, BLANK_CYCLES=2, DIGITS=4, DP_POS=2)
//  1 reset pulse -> anode=F seg=7F dp=1; after release anode=E appears after
//    cycle 2 of slot, idx wraps 3->0 every 32 cycles.
//  2 load bcd=16'h1234 -> from next boundary: idx0 seg=19, idx1 30, idx2 24
//    dp=0, idx3 79; seg=7F in every BLANK phase.
//  3 load 16'h5678 in mid-slot -> current slot keeps old digit; change only
//    after counter wraps.
//  4 bcd=16'h00A9 -> idx1 seg=3F; overflow=1 with load -> all digits 3F, dp=1.
//  5 LEADING_ZERO_BLANK_EN, bcd=16'h0005 -> idx3 7F, idx2 40 dp=0, idx0 12;
//    without macro idx3 = 40.
//  6 masterreset asserted mid-DRIVE -> same cycle anode=F seg=7F, no clk edge
//    needed; display blank until a new load propagates.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
// Shared constants for the stopwatch display path: active-low 7-segment
// patterns ({g,f,e,d,c,b,a}) and the slot-state type used by the digit scanner.
package stopwatch_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Slot state: BLANK keeps all anodes off at slot start, DRIVE lights one digit.
    typedef logic [0:0] slot_state_t;
    localparam slot_state_t ST_BLANK = 1'b0;
    localparam slot_state_t ST_DRIVE = 1'b1;

endpackage

// File: rtl/stopwatch_display_mux_bcd_to_seg7.sv
// bcd_to_seg7
// Combinational BCD nibble to active-low 7-segment decoder; non-BCD codes
// (A..F) render as a dash.
// Ports:
//   nibble  in   4   BCD digit
//   seg     out  7   {g,f,e,d,c,b,a}, active-low
module bcd_to_seg7
    import stopwatch_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (nibble)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/stopwatch_display_mux.sv
// stopwatch_display_mux
// Time-multiplexed common-anode 7-segment driver for the stopwatch count.
// A load strobe captures {overflow,bcd} into a shadow register; the shadow is
// promoted to the displayed (active) register only on a slot boundary so a
// digit never changes part-way through its slot. Each slot starts with
// BLANK_CYCLES of all-anodes-off to suppress ghosting.
// Optional feature macro: LEADING_ZERO_BLANK_EN -- blanks leading zero digits
// above the decimal point position (anode still driven).
// Ports:
//   clk          in   1          system clock, rising edge
//   masterreset  in   1          asynchronous reset, active-high
//   bcd          in   4*DIGITS   packed BCD, bcd[3:0] = digit 0
//   load         in   1          capture strobe for bcd/overflow
//   overflow     in   1          counter overflow, captured with load
//   anode        out  DIGITS     digit enables, active-low
//   seg          out  7          {g,f,e,d,c,b,a}, active-low
//   dp           out  1          decimal point, active-low
module stopwatch_display_mux
    import stopwatch_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 16,
    parameter int DP_POS       = 2
) (
    input  logic                  clk,
    input  logic                  masterreset,
    input  logic [4*DIGITS-1:0]   bcd,
    input  logic                  load,
    input  logic                  overflow,
    output logic [DIGITS-1:0]     anode,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK_END = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(DIGITS - 1);
    localparam logic [IDX_W-1:0] IDX_DP        = IDX_W'(DP_POS);

    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    slot_state_t         state;
    logic                boundary;

    logic [4*DIGITS-1:0] shadow_bcd;
    logic                shadow_ovf;
    logic [4*DIGITS-1:0] active_bcd;
    logic                active_ovf;

    logic [3:0]          nibble;
    logic [6:0]          dec_seg;
    logic                lz_blank;

    assign boundary = (cnt == CNT_LAST);

    // Slot counter, digit index and slot state. The state register tracks
    // cnt < BLANK_CYCLES: it enters DRIVE on the edge that moves cnt to
    // BLANK_CYCLES and returns to BLANK on the wrap.
    always_ff @(posedge clk or posedge masterreset) begin
        if (masterreset) begin
            cnt   <= '0;
            idx   <= '0;
            state <= ST_BLANK;
        end else if (boundary) begin
            cnt   <= '0;
            idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            state <= ST_BLANK;
        end else begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_BLANK_END)
                state <= ST_DRIVE;
        end
    end

    // Shadow captures on load; active follows shadow only at the boundary.
    // A load on the boundary cycle lands in shadow while active takes the
    // previous shadow, so it shows one slot later.
    always_ff @(posedge clk or posedge masterreset) begin
        if (masterreset) begin
            shadow_bcd <= '0;
            shadow_ovf <= 1'b0;
            active_bcd <= '0;
            active_ovf <= 1'b0;
        end else begin
            if (load) begin
                shadow_bcd <= bcd;
                shadow_ovf <= overflow;
            end
            if (boundary) begin
                active_bcd <= shadow_bcd;
                active_ovf <= shadow_ovf;
            end
        end
    end

    assign nibble = active_bcd[4*int'(idx) +: 4];

    bcd_to_seg7 u_dec (
        .nibble (nibble),
        .seg    (dec_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // Walk from the most significant digit down; lz_run stays set while the
    // current nibble and every nibble above it are zero.
    always_comb begin
        logic lz_run;
        int unsigned i;
        lz_run   = 1'b1;
        lz_blank = 1'b0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            i      = DIGITS - 1 - k;
            lz_run = lz_run & (active_bcd[4*i +: 4] == 4'd0);
            if ((i > DP_POS) && (i == int'(idx)))
                lz_blank = lz_run;
        end
    end
`else
    assign lz_blank = 1'b0;
`endif

    // Registered outputs: reflect the counter/index state of the previous cycle.
    always_ff @(posedge clk or posedge masterreset) begin
        if (masterreset) begin
            anode <= '1;
            seg   <= SEG_BLANK;
            dp    <= 1'b1;
        end else if (state == ST_BLANK) begin
            anode <= '1;
            seg   <= SEG_BLANK;
            dp    <= 1'b1;
        end else begin
            anode <= ~(DIGITS'(1) << idx);
            if (active_ovf)
                seg <= SEG_DASH;
            else if (lz_blank)
                seg <= SEG_BLANK;
            else
                seg <= dec_seg;
            dp <= !((idx == IDX_DP) && !active_ovf);
        end
    end

endmodule
